// File: rtl/layer_sequencer_if.sv
// Purpose: control handshake bundle between a layer sequencer and its datapath.
// Signals:
//   start, ld_buf_done, pe_done, ctrl_done  -> into the sequencer
//   init_ld, ld_buf, pe_start, mem_wr_en    -> datapath controls from the sequencer
//   busy, done, err, tile_cnt[TILE_W]       -> sequencer status
// Modports: master = sequencer side, slave = datapath / layer-chaining side.
interface layer_sequencer_if #(
  parameter int unsigned TILE_W = 8
);
  logic              start;
  logic              ld_buf_done;
  logic              pe_done;
  logic              ctrl_done;
  logic              init_ld;
  logic              ld_buf;
  logic              pe_start;
  logic              mem_wr_en;
  logic              busy;
  logic              done;
  logic              err;
  logic [TILE_W-1:0] tile_cnt;

  modport master (
    input  start, ld_buf_done, pe_done, ctrl_done,
    output init_ld, ld_buf, pe_start, mem_wr_en, busy, done, err, tile_cnt
  );

  modport slave (
    output start, ld_buf_done, pe_done, ctrl_done,
    input  init_ld, ld_buf, pe_start, mem_wr_en, busy, done, err, tile_cnt
  );
endinterface

// File: rtl/layer_sequencer.sv
// Purpose: sequences one convolution layer (init load, buffer fill, PE run,
//   result write-back) tile by tile, with a tile counter and a per-wait
//   watchdog that aborts a hung datapath instead of deadlocking.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active-high
//   bus  - layer_sequencer_if.master: start/ld_buf_done/pe_done/ctrl_done in;
//          init_ld/ld_buf/pe_start/mem_wr_en/busy/done/err/tile_cnt out
// All outputs are registered and decoded from the state being entered, so
// each one is a pure function of the current state (err/tile_cnt are the
// sticky/counting exceptions).
module layer_sequencer #(
  parameter int unsigned NUM_TILES = 16,
  parameter int unsigned TILE_W    = 8,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned TO_W      = 11
) (
  input  logic               clk,
  input  logic               rst,
  layer_sequencer_if.master  bus
);

  localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);
  localparam logic [TILE_W-1:0] MAX_TILE  = TILE_W'(NUM_TILES);
  localparam logic [TO_W-1:0]   WD_LAST   = TO_W'(TIMEOUT - 1);
  localparam bit                WD_EN     = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LOAD,
    S_COMPUTE,
    S_WAIT_PE,
    S_WRITE,
    S_FINISH,
    S_ABORT
  } state_t;

  state_t            state, state_n;
  logic [TO_W-1:0]   wd_cnt, wd_cnt_n;
  logic [TILE_W-1:0] tile_cnt, tile_cnt_n;
  logic              err, err_n;
  logic              init_ld, ld_buf, pe_start, mem_wr_en, busy, done;
  logic              wd_hit;

  // Watchdog expiry for the current wait cycle
  assign wd_hit = WD_EN && (wd_cnt == WD_LAST);

  // Next state, watchdog, counter and sticky error
  always_comb begin
    state_n    = state;
    wd_cnt_n   = wd_cnt;
    tile_cnt_n = tile_cnt;
    err_n      = err;

    case (state)
      S_IDLE:    if (bus.start) state_n = S_INIT;
      S_INIT:    state_n = S_LOAD;
      S_LOAD: begin
        // A done input in the expiry cycle takes priority over the abort
        if (bus.ld_buf_done) state_n = S_COMPUTE;
        else if (wd_hit)     state_n = S_ABORT;
      end
      S_COMPUTE: state_n = S_WAIT_PE;
      S_WAIT_PE: begin
        if (bus.pe_done) state_n = S_WRITE;
        else if (wd_hit) state_n = S_ABORT;
      end
      S_WRITE: begin
        if (bus.ctrl_done || (tile_cnt == LAST_TILE)) state_n = S_FINISH;
        else                                          state_n = S_LOAD;
      end
      S_FINISH:  state_n = S_IDLE;
      S_ABORT:   state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase

    // Watchdog restarts on every state entry and only runs while waiting
    if (state_n != state) begin
      wd_cnt_n = '0;
    end else if (WD_EN && ((state == S_LOAD) || (state == S_WAIT_PE))) begin
      wd_cnt_n = wd_cnt + TO_W'(1);
    end

    // Tile count saturates at NUM_TILES and holds until the next start
    if ((state == S_IDLE) && bus.start) begin
      tile_cnt_n = '0;
    end else if ((state == S_WRITE) && (tile_cnt != MAX_TILE)) begin
      tile_cnt_n = tile_cnt + TILE_W'(1);
    end

    if ((state == S_IDLE) && bus.start) begin
      err_n = 1'b0;
    end else if (state_n == S_ABORT) begin
      err_n = 1'b1;
    end
  end

  // State and registered Moore outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      wd_cnt    <= '0;
      tile_cnt  <= '0;
      err       <= 1'b0;
      init_ld   <= 1'b0;
      ld_buf    <= 1'b0;
      pe_start  <= 1'b0;
      mem_wr_en <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      wd_cnt    <= wd_cnt_n;
      tile_cnt  <= tile_cnt_n;
      err       <= err_n;
      init_ld   <= (state_n == S_INIT);
      ld_buf    <= (state_n == S_LOAD);
      pe_start  <= (state_n == S_COMPUTE);
      mem_wr_en <= (state_n == S_WRITE);
      busy      <= (state_n != S_IDLE);
      done      <= (state_n == S_FINISH);
    end
  end

  assign bus.init_ld   = init_ld;
  assign bus.ld_buf    = ld_buf;
  assign bus.pe_start  = pe_start;
  assign bus.mem_wr_en = mem_wr_en;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err;
  assign bus.tile_cnt  = tile_cnt;

endmodule

// File: tb/tb_layer_sequencer.sv
// Purpose: directed self-checking bench for layer_sequencer (NUM_TILES=3,
//   TIMEOUT=8). A per-cycle datapath responder answers ld_buf / WAIT_PE with
//   a programmable latency; expected cycle positions are hand-derived.
module tb_layer_sequencer;

  localparam int unsigned NT  = 3;
  localparam int unsigned TW  = 8;
  localparam int unsigned TO  = 8;
  localparam int unsigned TOW = 11;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  layer_sequencer_if #(.TILE_W(TW)) bus ();

  layer_sequencer #(
    .NUM_TILES(NT),
    .TILE_W   (TW),
    .TIMEOUT  (TO),
    .TO_W     (TOW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // {init_ld, ld_buf, pe_start, mem_wr_en, busy, done, err}
  logic [6:0] outs;
  assign outs = {bus.init_ld, bus.ld_buf, bus.pe_start, bus.mem_wr_en,
                 bus.busy, bus.done, bus.err};

  int errors = 0;
  int checks = 0;

  int n_wr, n_done, n_init, wr_gap, done_cyc, err_cyc, wait_len;
  int busy_after, err_at_init;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start       = 1'b0;
    bus.ld_buf_done = 1'b0;
    bus.pe_done     = 1'b0;
    bus.ctrl_done   = 1'b0;
  endtask

  // Runs one layer. lat: cycles the datapath waits before answering;
  // ctrl_at: write number that carries ctrl_done (0 = never); pe_en: answer
  // pe at all; noise: hold every done input and start high where they must
  // be ignored. Cycle 0 is the INIT cycle.
  task automatic run_layer(input int lat, input int ctrl_at, input bit pe_en,
                           input bit noise);
    int ld_cnt = 0;
    int wcnt = 0;
    int last_wr = -1;
    int cyc = 0;
    bit wait_pe;
    bit fin = 1'b0;
    bit done_prev = 1'b0;
    bit timed_out = 1'b0;
    n_wr = 0; n_done = 0; n_init = 0; wr_gap = -1; done_cyc = -1;
    err_cyc = -1; wait_len = 0; busy_after = -1;

    bus.start = 1'b1;
    tick();
    bus.start = noise;
    check("init_latency", int'(bus.init_ld), 1);
    err_at_init = int'(bus.err);

    while (!fin) begin
      if (cyc > 300) begin
        timed_out = 1'b1;
        break;
      end
      if (done_prev) begin
        busy_after = int'(bus.busy);
        fin = 1'b1;
      end
      wait_pe = bus.busy && !(bus.init_ld || bus.ld_buf || bus.pe_start ||
                              bus.mem_wr_en || bus.done || bus.err);
      if (bus.init_ld) n_init++;
      if (bus.mem_wr_en) begin
        n_wr++;
        if (last_wr >= 0) wr_gap = cyc - last_wr;
        last_wr = cyc;
      end
      if (bus.done) begin
        n_done++;
        done_prev = 1'b1;
        done_cyc = cyc;
      end
      if (bus.err && (err_cyc < 0)) err_cyc = cyc;
      if (bus.err && !bus.busy) fin = 1'b1;
      ld_cnt = bus.ld_buf ? ld_cnt + 1 : 0;
      wcnt   = wait_pe ? wcnt + 1 : 0;
      if (wait_pe) wait_len = wcnt;

      if (fin) begin
        idle_inputs();
      end else begin
        bus.ld_buf_done = noise || (bus.ld_buf && (ld_cnt > lat));
        bus.pe_done     = noise || (pe_en && wait_pe && (wcnt > lat));
        bus.ctrl_done   = (bus.mem_wr_en && (n_wr == ctrl_at)) ||
                          (noise && !bus.mem_wr_en);
        tick();
        cyc++;
      end
    end
    idle_inputs();
    check("run_timeout", int'(timed_out), 0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("reset_outs", int'(outs), 0);
    check("reset_tile_cnt", int'(bus.tile_cnt), 0);
    rst = 1'b0;
    tick();
    check("idle_outs", int'(outs), 0);

    // Full layer, 2-cycle datapath latency: 8-cycle tiles, done at cycle 25
    run_layer(2, 0, 1'b1, 1'b0);
    check("t1_writes", n_wr, 3);
    check("t1_done_pulses", n_done, 1);
    check("t1_init_pulses", n_init, 1);
    check("t1_tile_period", wr_gap, 8);
    check("t1_done_cycle", done_cyc, 25);
    check("t1_busy_after_done", busy_after, 0);
    check("t1_tile_cnt", int'(bus.tile_cnt), 3);
    check("t1_err", int'(bus.err), 0);

    // Early end via ctrl_done on the 2nd write: 6-cycle tiles, done at 13
    run_layer(1, 2, 1'b1, 1'b0);
    check("t2_writes", n_wr, 2);
    check("t2_done_pulses", n_done, 1);
    check("t2_done_cycle", done_cyc, 13);
    check("t2_tile_cnt", int'(bus.tile_cnt), 2);

    // PE never answers: 8 WAIT_PE cycles (3..10), ABORT at 11, no done
    run_layer(0, 0, 1'b0, 1'b0);
    check("t3_wait_len", wait_len, 8);
    check("t3_err_cycle", err_cyc, 11);
    check("t3_done_pulses", n_done, 0);
    check("t3_writes", n_wr, 0);
    tick();
    tick();
    check("t3_err_sticky", int'(bus.err), 1);
    check("t3_idle_after_abort", int'(bus.busy), 0);
    check("t3_tile_cnt", int'(bus.tile_cnt), 0);

    // Done inputs held high, start and ctrl_done held high where ignored
    run_layer(0, 0, 1'b1, 1'b1);
    check("t4_err_cleared_by_start", err_at_init, 0);
    check("t4_tile_period", wr_gap, 4);
    check("t4_done_cycle", done_cyc, 13);
    check("t4_writes", n_wr, 3);
    check("t4_init_pulses", n_init, 1);
    check("t6_no_restart_after_finish", busy_after, 0);
    tick();
    check("t6_still_idle", int'(outs), 0);

    // Reset in WAIT_PE of tile 1 clears outputs without waiting for a clock
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.ld_buf_done = 1'b1;
    tick();
    tick();
    bus.ld_buf_done = 1'b0;
    tick();
    check("t5_in_wait_pe", int'(outs), 4);
    rst = 1'b1;
    #1;
    check("t5_async_outs", int'(outs), 0);
    check("t5_async_tile_cnt", int'(bus.tile_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.pe_done = 1'b1;
    tick();
    bus.pe_done = 1'b0;
    tick();
    check("t5_idle_after_reset", int'(outs), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
